// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode-side controls in, instruction-memory and IF/ID outputs.
// master = fetch stage, slave = decode stage / instruction memory side.
interface fetch_stage_if;
    logic        stall;
    logic        jump;
    logic [25:0] jump_index;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;

    modport master (
        input  stall, jump, jump_index, branch_taken, branch_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault
    );

    modport slave (
        output stall, jump, jump_index, branch_taken, branch_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, redirect/flush, stall hold and IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_BITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic {ST_RUN, ST_FAULT} state_t;
`else
    typedef enum logic {ST_RUN} state_t;
`endif

    if (IMEM_ADDR_BITS < 1 || IMEM_ADDR_BITS > 30) begin : g_bad_addr_bits
        $error("fetch_stage: IMEM_ADDR_BITS must be in 1..30");
    end

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_redirect_target;
    logic        w_redirect;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_jump_target     = {r_pc4[31:28], bus.jump_index, 2'b00};
    assign w_redirect        = bus.jump | bus.branch_taken;
    assign w_redirect_target = bus.jump ? w_jump_target : bus.branch_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;
    logic w_misaligned;
    assign w_misaligned    = (w_redirect_target[1:0] != 2'b00);
    assign bus.fetch_fault = r_fault;
`else
    logic [31:0] w_aligned_target;
    assign w_aligned_target = w_redirect_target & ~32'd3;
    assign bus.fetch_fault  = 1'b0;
`endif

    assign bus.imem_addr      = r_pc;
    assign bus.if_id_instr    = r_instr;
    assign bus.if_id_pc_plus4 = r_pc4;
    assign bus.if_id_valid    = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_redirect) begin
                        // Jump has already won the target mux; the redirect edge is the single bubble.
                        r_instr <= '0;
                        r_pc4   <= '0;
                        r_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (w_misaligned) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= w_redirect_target;
                        end
`else
                        r_pc <= w_aligned_target;
`endif
                    end else if (!bus.stall) begin
                        r_pc    <= w_pc_plus4;
                        r_instr <= bus.imem_rdata;
                        r_pc4   <= w_pc_plus4;
                        r_valid <= 1'b1;
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                ST_FAULT: begin
                    // Locked until reset: pc keeps the redirect source, IF/ID stays flushed.
                    r_instr <= '0;
                    r_pc4   <= '0;
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end
`endif
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, misaligned-redirect sequence, random vs model.
module tb_fetch_stage;

    localparam logic [31:0] RP = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    // Instruction memory image: every word encodes its own address.
    assign bus.imem_rdata = 32'h2000_0000 | bus.imem_addr;

    fetch_stage #(
        .RESET_PC      (RP),
        .IMEM_ADDR_BITS(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        jump;
        logic [25:0] jidx;
        logic        br;
        logic [31:0] btgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic stall, logic jump, logic [25:0] jidx,
                               logic br, logic [31:0] btgt, logic [31:0] e_pc,
                               logic [31:0] e_instr, logic [31:0] e_pc4, logic e_valid);
        vec_t r;
        r.rst = rst; r.stall = stall; r.jump = jump; r.jidx = jidx;
        r.br = br; r.btgt = btgt; r.e_pc = e_pc; r.e_instr = e_instr;
        r.e_pc4 = e_pc4; r.e_valid = e_valid;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic stall, logic jump, logic [25:0] jidx,
                         logic br, logic [31:0] btgt);
        reset             = rst;
        bus.stall         = stall;
        bus.jump          = jump;
        bus.jump_index    = jidx;
        bus.branch_taken  = br;
        bus.branch_target = btgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic [31:0] pc, logic [31:0] instr,
                           logic [31:0] pc4, logic valid, logic fault);
        chk({tag, "_pc"},    bus.imem_addr,      pc);
        chk({tag, "_instr"}, bus.if_id_instr,    instr);
        chk({tag, "_pc4"},   bus.if_id_pc_plus4, pc4);
        chk({tag, "_valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
        chk({tag, "_fault"}, {31'd0, bus.fetch_fault}, {31'd0, fault});
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault;

    task automatic model_step(logic rst, logic stall, logic jump, logic [25:0] jidx,
                              logic br, logic [31:0] btgt);
        logic [31:0] tgt;
        if (rst) begin
            m_pc = RP; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
        end else if (m_fault) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (jump || br) begin
            tgt = jump ? ((m_pc4 & 32'hF000_0000) + ({6'd0, jidx} * 32'd4)) : btgt;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (ALIGN && (tgt % 4 != 0)) m_fault = 1;
            else m_pc = tgt - (tgt % 4);
        end else if (!stall) begin
            m_instr = 32'h2000_0000 | m_pc;
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1;
        end
    endtask

    initial begin
        drive(1, 0, 0, '0, 0, '0);

        // Directed table: inputs applied before the edge, outputs expected after it
        vecs.push_back(v(1,0,0,26'h0,0,32'h0,        32'h0000_0000, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0004, 32'h2000_0000, 32'h0000_0004, 1));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1));
        vecs.push_back(v(0,1,0,26'h0,0,32'h0,        32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1));
        vecs.push_back(v(0,1,0,26'h0,0,32'h0,        32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_000C, 32'h2000_0008, 32'h0000_000C, 1));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0010, 32'h2000_000C, 32'h0000_0010, 1));
        vecs.push_back(v(0,1,0,26'h0,1,32'h40,       32'h0000_0040, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0044, 32'h2000_0040, 32'h0000_0044, 1));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0048, 32'h2000_0044, 32'h0000_0048, 1));
        vecs.push_back(v(0,0,0,26'h0,1,32'h1000_0000,32'h1000_0000, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h1000_0004, 32'h3000_0000, 32'h1000_0004, 1));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h1000_0008, 32'h3000_0004, 32'h1000_0008, 1));
        vecs.push_back(v(0,0,1,26'h10,1,32'h80,      32'h1000_0040, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h1000_0044, 32'h3000_0040, 32'h1000_0044, 1));
        vecs.push_back(v(0,0,0,26'h0,1,32'hFFFF_FFFC,32'hFFFF_FFFC, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0004, 32'h2000_0000, 32'h0000_0004, 1));
        vecs.push_back(v(1,1,1,26'h3,1,32'h100,      32'h0000_0000, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h0000_0004, 32'h2000_0000, 32'h0000_0004, 1));
        vecs.push_back(v(0,0,1,26'h3FF_FFFF,0,32'h0, 32'h0FFF_FFFC, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,1,0,26'h0,0,32'h0,        32'h0FFF_FFFC, 32'h0,         32'h0,         0));
        vecs.push_back(v(0,0,0,26'h0,0,32'h0,        32'h1000_0000, 32'h2FFF_FFFC, 32'h1000_0000, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].jump, vecs[i].jidx, vecs[i].br, vecs[i].btgt);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_pc4, vecs[i].e_valid, 1'b0);
        end

        // Misaligned branch target 0x42 taken at pc 0x20
        drive(1, 0, 0, '0, 0, '0); tick();
        drive(0, 0, 0, '0, 1, 32'h20); tick();
        chk_all("mis_setup", 32'h20, 32'h0, 32'h0, 0, 0);
        drive(0, 0, 0, '0, 1, 32'h42); tick();
`ifdef FETCH_ALIGN_CHECK_EN
        chk_all("mis_trap", 32'h20, 32'h0, 32'h0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, i[0], i[1], 26'h55, i[2], 32'h100);
            tick();
            chk_all($sformatf("mis_hold%0d", i), 32'h20, 32'h0, 32'h0, 0, 1);
        end
        drive(1, 0, 0, '0, 0, '0); tick();
        chk_all("mis_reset", RP, 32'h0, 32'h0, 0, 0);
`else
        chk_all("mis_force", 32'h40, 32'h0, 32'h0, 0, 0);
        drive(0, 0, 0, '0, 0, '0); tick();
        chk_all("mis_next", 32'h44, 32'h2000_0040, 32'h44, 1, 0);
`endif

        // Randomized stimulus against the model
        for (int c = 0; c < 600; c++) begin
            logic        r_rst, r_st, r_j, r_b;
            logic [25:0] r_ji;
            logic [31:0] r_bt;
            r_rst = (c == 0) || ($urandom_range(0, 24) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_j   = ($urandom_range(0, 7) == 0);
            r_b   = ($urandom_range(0, 5) == 0);
            r_ji  = 26'($urandom);
            r_bt  = $urandom;
            if ($urandom_range(0, 7) != 0) r_bt = r_bt & 32'hFFFF_FFFC;
            drive(r_rst, r_st, r_j, r_ji, r_b, r_bt);
            model_step(r_rst, r_st, r_j, r_ji, r_b, r_bt);
            tick();
            chk_all($sformatf("rnd%0d", c), m_pc, m_instr, m_pc4, m_valid, m_fault);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/register-file/ALU datapath.
- Owns the program counter and drives the instruction-memory address.
- Latches each fetched word, with its PC+4, into an IF/ID pipeline register for the decode stage.
- Handles sequential fetch, jump/branch redirect with flush, decode-requested stalls and an optional misaligned-target fault.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_ADDR_BITS, 8, word-address bits decoded by instruction memory; the PC itself is always 32-bit.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (load-use hazard from decode)
- jump  input  1  jump resolved in decode this cycle
- jump_index  input  26  instr[25:0] of the jump held in IF/ID
- branch_taken  input  1  taken branch resolved this cycle
- branch_target  input  32  byte address of branch target
- imem_addr  output  32  current PC, driven to instruction memory
- imem_rdata  input  32  instruction word; combinational read, valid in same cycle
- if_id_instr  output  32  latched instruction
- if_id_pc_plus4  output  32  latched PC+4 of that instruction
- if_id_valid  output  1  IF/ID holds a real instruction
- fetch_fault  output  1  misaligned redirect trapped (optional feature; else tied 0)

Behaviour:
- imem_addr = pc register, combinational; no internal memory.
- pc_plus4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
- States: RUN, FAULT. FAULT exists only with the optional feature.
- Reset (highest priority, any state, mid-redirect or mid-stall):
  - pc = RESET_PC
  - if_id_instr = 32'h0, if_id_pc_plus4 = 32'h0, if_id_valid = 0, fetch_fault = 0
  - state = RUN
- RUN, per rising edge, priority order:
  1. jump = 1: pc <= jump target; IF/ID flushed (instr 0, valid 0, pc_plus4 0). Overrides stall and branch_taken.
  2. branch_taken = 1: pc <= branch_target; IF/ID flushed. Overrides stall.
  3. stall = 1: pc and all IF/ID fields hold.
  4. Otherwise: pc <= pc_plus4; if_id_instr <= imem_rdata; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
- Latency: an instruction at address A appears in IF/ID one edge after imem_addr = A.
- Redirect: the edge accepting the redirect produces exactly one bubble; the target's instruction is in IF/ID on the following edge, unless stalled.
- Simultaneous jump and branch_taken: jump wins; branch is dropped with no second bubble.
- First cycle after reset release: pc = RESET_PC, if_id_valid = 0. First valid IF/ID one edge later.
- Redirect target bits [1:0] nonzero: handled by the optional feature.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect whose target[1:0] != 2'b00 (branch_target, or jump target, which is always aligned) moves state to FAULT on that edge, instead of loading pc.
  - In FAULT: fetch_fault = 1; pc holds the faulting redirect's source pc; IF/ID flushed and held invalid.
  - All inputs are ignored in FAULT until reset.
- Undefined:
  - Target bits [1:0] are forced to 2'b00 before loading pc.
  - fetch_fault is constant 0; no FAULT state is synthesised.

Test Plan:
- Reset, then 4 free-running edges with imem_rdata = 32'h2000_0000 | addr → imem_addr 0,4,8,12; if_id_pc_plus4 4,8,12; if_id_valid 0 then 1.
- Stall for 2 edges at pc = 8 → pc stays 8; IF/ID keeps instr of addr 4 and pc_plus4 = 8; sequential fetch resumes at 12 after release.
- branch_taken with branch_target = 32'h40 while stall = 1 at pc = 16 → next pc = 32'h40, if_id_valid = 0; next edge IF/ID holds the instr at 32'h40 with pc_plus4 = 32'h44.
- jump and branch_taken together, if_id_pc_plus4 = 32'h1000_0008, jump_index = 26'h10, branch_target = 32'h80 → pc = 32'h1000_0040; branch ignored; one bubble.
- reset = 0, pc at 32'hFFFF_FFFC, no stall → next pc = 0; if_id_pc_plus4 = 0.
- FETCH_ALIGN_CHECK_EN defined, branch_target = 32'h42 at pc = 32'h20 → fetch_fault = 1; pc stays 32'h20; valid 0 for 10 edges; reset clears fault and pc = RESET_PC. Macro undefined, same stimulus → pc = 32'h40, fetch_fault = 0.
